motor_cmd_decoder: RTL and testbench
====================================

// Module: motor_cmd_decoder
// PURPOSE
//  Framed command decoder between serial_rx and pwm. Consumes received UART bytes (data/new_data),
//  validates 3-byte frames [SYNC, CMD, ~CMD], and holds the accepted CMD as the motor action byte.
//  A link watchdog forces a safe stop action when no valid frame arrives in time, so the robot
//  never keeps driving on a lost or corrupted serial link.
// PARAMETERS
//  SYNC_BYTE        8'hAA       frame start byte
//  SAFE_ACTION      8'h00       action driven after reset and on watchdog expiry (motors stopped)
//  WDOG_CYCLES      25_000_000  clk cycles without a valid frame before timeout (0.5 s @ 50 MHz)
//  BYTE_TMO_CYCLES  500_000     max clk cycles between bytes inside one frame (10 ms @ 50 MHz)
// PORTS
//  clk            in   1  system clock, 50 MHz
//  rst_n          in   1  asynchronous reset, active low
//  rx_data        in   8  byte from serial_rx, valid only while rx_new=1
//  rx_new         in   1  single-cycle strobe from serial_rx: rx_data holds a new byte
//  action         out  8  registered motor action byte to pwm
//  action_update  out  1  single-cycle pulse: action changed source (valid frame or watchdog)
//  timeout        out  1  level: 1 while watchdog expired / no valid frame since reset
//  err_count      out  8  saturating count of rejected frames (bad check or byte timeout)
// BEHAVIOUR
//  Reset (async, rst_n=0): action=SAFE_ACTION, action_update=0, timeout=1, err_count=0,
//   FSM=IDLE, byte timer=0, watchdog counter=0. Mid-frame reset discards the partial frame.
//  FSM (advances only on cycles with rx_new=1, except byte timeout):
//   IDLE:     rx_data==SYNC_BYTE -> GOT_SYNC; any other byte ignored, no error.
//   GOT_SYNC: any byte (incl. SYNC_BYTE) captured as cmd -> GOT_CMD.
//   GOT_CMD:  rx_data==~cmd -> accept, -> IDLE.
//             else err_count+1; if rx_data==SYNC_BYTE -> GOT_SYNC (resync), else -> IDLE.
//  Byte timer: cleared on every rx_new; counts while in GOT_SYNC/GOT_CMD; at BYTE_TMO_CYCLES-1
//   -> IDLE, err_count+1. Not counting in IDLE.
//  Accept: on the edge sampling the valid check byte: action<=cmd, action_update<=1 (next cycle
//   only), timeout<=0, watchdog<=0. Latency rx_new(check) -> action visible: 1 clk.
//   action_update pulses on every accepted frame, even if cmd equals current action.
//  Watchdog: counts every cycle while timeout=0; reaching WDOG_CYCLES-1 -> action<=SAFE_ACTION,
//   timeout<=1, action_update<=1 for one cycle, counter holds. While timeout=1 no further pulses.
//  Simultaneous accept and watchdog expiry in one cycle: accept wins, no SAFE pulse.
//  Simultaneous byte timeout and rx_new in one cycle: rx_new wins (byte processed, timer cleared).
//  err_count saturates at 8'hFF; increments at most once per cycle.
//  Counter widths $clog2 of respective parameters; no wrap-around of either counter.
//  rx_data is sampled only when rx_new=1; action never changes except on accept/expiry/reset.
// TESTING
//  1 Reset release, no stimulus -> action=8'h00, timeout=1, err_count=0, no action_update.
//  2 Bytes AA,3C,C3 -> 1 clk after C3 strobe: action=8'h3C, action_update 1-cycle, timeout=0.
//  3 Bytes AA,3C,00 -> action unchanged, err_count=1; then AA,AA,55 -> action=8'hAA accepted.
//  4 Bytes AA,3C,AA,12,ED (resync) -> err_count=1, action=8'h12.
//  5 AA then 500_000 idle cycles then 3C,C3 -> err_count=1, action unchanged (3C ignored in IDLE).
//  6 Valid frame 5A,A5 then silence 25_000_000 cycles -> action=8'h00, timeout=1, one
//    action_update; bench may override WDOG_CYCLES=100, BYTE_TMO_CYCLES=20 for runtime.

Source files
------------

// File: rtl/motor_cmd_decoder.sv
// Framed UART command decoder: validates [SYNC, CMD, ~CMD] frames, holds the
// accepted CMD as the motor action, and falls back to a safe action when the
// link goes quiet for too long.
module motor_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE       = 8'hAA,
  parameter logic [7:0]  SAFE_ACTION     = 8'h00,
  parameter int unsigned WDOG_CYCLES     = 25_000_000,
  parameter int unsigned BYTE_TMO_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_new_i,
  output logic [7:0] action_o,
  output logic       action_update_o,
  output logic       timeout_o,
  output logic [7:0] err_count_o
);

  localparam int unsigned WdogW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam int unsigned TmoW  = (BYTE_TMO_CYCLES > 1) ? $clog2(BYTE_TMO_CYCLES) : 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_CYCLES - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(BYTE_TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGotSync,
    StGotCmd
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [TmoW-1:0]  tmr_q, tmr_d;
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic [7:0]       action_q, action_d;
  logic             update_q, update_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       err_q, err_d;
  logic             accept, reject;

  // Frame parser and inter-byte timer; a strobe always takes priority over the timer.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    reject  = 1'b0;
    if (rx_new_i) begin
      tmr_d = '0;
      unique case (state_q)
        StIdle: begin
          if (rx_data_i == SYNC_BYTE) state_d = StGotSync;
        end
        StGotSync: begin
          cmd_d   = rx_data_i;
          state_d = StGotCmd;
        end
        StGotCmd: begin
          if (rx_data_i == ~cmd_q) begin
            accept  = 1'b1;
            state_d = StIdle;
          end else begin
            reject  = 1'b1;
            // A failed check byte that is itself SYNC starts the next frame.
            state_d = (rx_data_i == SYNC_BYTE) ? StGotSync : StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmr_q == TmoLast) begin
        reject  = 1'b1;
        state_d = StIdle;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q + TmoW'(1);
      end
    end
  end

  // Action source selection, link watchdog and saturating error count.
  always_comb begin
    action_d  = action_q;
    update_d  = 1'b0;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    err_d     = err_q;
    if (reject && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (accept) begin
      // Accept beats a coincident watchdog expiry.
      action_d  = cmd_q;
      update_d  = 1'b1;
      timeout_d = 1'b0;
      wdog_d    = '0;
    end else if (!timeout_q) begin
      if (wdog_q == WdogLast) begin
        action_d  = SAFE_ACTION;
        update_d  = 1'b1;
        timeout_d = 1'b1;
      end else begin
        wdog_d = wdog_q + WdogW'(1);
      end
    end
  end

  // State registers; reset lands in the safe, timed-out condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      tmr_q     <= '0;
      wdog_q    <= '0;
      action_q  <= SAFE_ACTION;
      update_q  <= 1'b0;
      timeout_q <= 1'b1;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      tmr_q     <= tmr_d;
      wdog_q    <= wdog_d;
      action_q  <= action_d;
      update_q  <= update_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign action_o        = action_q;
  assign action_update_o = update_q;
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_q;

endmodule

// File: tb/tb_motor_cmd_decoder.sv
// Scoreboard bench for motor_cmd_decoder with a frame-level reference model.
module tb_motor_cmd_decoder;

  localparam int unsigned W    = 100;
  localparam int unsigned T    = 20;
  localparam logic [7:0]  SYNC = 8'hAA;
  localparam logic [7:0]  SAFE = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_new = 1'b0;
  logic [7:0] action_o;
  logic       action_update_o;
  logic       timeout_o;
  logic [7:0] err_count_o;

  motor_cmd_decoder #(
    .SYNC_BYTE      (SYNC),
    .SAFE_ACTION    (SAFE),
    .WDOG_CYCLES    (W),
    .BYTE_TMO_CYCLES(T)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data_i      (rx_data),
    .rx_new_i       (rx_new),
    .action_o       (action_o),
    .action_update_o(action_update_o),
    .timeout_o      (timeout_o),
    .err_count_o    (err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] action;
    logic       timeout;
    logic [7:0] err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: edge index, pending frame bytes, times of last byte/accept.
  int         e = 0;
  logic [7:0] m_frame[$];
  int         m_last_byte = 0;
  int         m_last_acc = 0;
  bit         m_expired = 1'b1;
  int         m_err = 0;
  logic [7:0] m_action = SAFE;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void m_reset();
    m_frame.delete();
    exp_q.delete();
    m_expired = 1'b1;
    m_err = 0;
    m_action = SAFE;
  endfunction

  function automatic void m_bump_err();
    if (m_err < 255) m_err++;
  endfunction

  // Apply one clock edge to the model; has=1 means a byte was strobed at this edge.
  function automatic void m_edge(bit has, logic [7:0] b);
    bit         acc;
    logic [7:0] cmd;
    acc = 1'b0;
    cmd = 8'h00;
    if (has) begin
      m_last_byte = e;
      if (m_frame.size() == 0) begin
        if (b == SYNC) m_frame.push_back(b);
      end else if (m_frame.size() == 1) begin
        m_frame.push_back(b);
      end else begin
        cmd = m_frame[1];
        m_frame.delete();
        if (b == ~cmd) acc = 1'b1;
        else begin
          m_bump_err();
          if (b == SYNC) m_frame.push_back(b);
        end
      end
    end else if (m_frame.size() != 0 && (e - m_last_byte) == int'(T)) begin
      m_bump_err();
      m_frame.delete();
    end
    if (acc) begin
      m_last_acc = e;
      m_expired  = 1'b0;
      m_action   = cmd;
      exp_q.push_back('{action: cmd, timeout: 1'b0, err: m_err[7:0]});
    end else if (!m_expired && (e - m_last_acc) == int'(W)) begin
      m_expired = 1'b1;
      m_action  = SAFE;
      exp_q.push_back('{action: SAFE, timeout: 1'b1, err: m_err[7:0]});
    end
  endfunction

  // Monitor: every action_update pulse must match the oldest expected event.
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && action_update_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 32'd1, 32'd0);
      end else begin
        x = exp_q.pop_front();
        chk("upd_action", action_o, x.action);
        chk("upd_timeout", timeout_o, x.timeout);
        chk("upd_err", err_count_o, x.err);
      end
    end
  end

  task automatic cyc(bit has, logic [7:0] b);
    rx_new  = has;
    rx_data = has ? b : 8'($urandom);
    @(posedge clk);
    e++;
    m_edge(has, b);
    #1;
    rx_new = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  task automatic send(logic [7:0] b, int gap);
    idle(gap);
    cyc(1'b1, b);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rx_new = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Let pending pulses drain, then compare the held state with the model.
  task automatic settle(string tag);
    idle(2);
    @(negedge clk);
    #1;
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_action"}, action_o, m_action);
    chk({tag, "_timeout"}, timeout_o, m_expired);
    chk({tag, "_err"}, err_count_o, m_err);
  endtask

  function automatic int rg();
    return ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 3);
  endfunction

  initial begin
    #5ms;
    $display("FAIL tb_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] c;
    int         kind;

    // 1: reset state, no stimulus
    do_reset();
    idle(5);
    chk("t1_action", action_o, 8'h00);
    chk("t1_timeout", timeout_o, 1);
    chk("t1_err", err_count_o, 0);
    settle("t1");

    // 2: valid frame, one-clock latency
    do_reset();
    send(8'hAA, 0);
    send(8'h3C, 0);
    send(8'hC3, 0);
    chk("t2_action", action_o, 8'h3C);
    chk("t2_update", action_update_o, 1);
    chk("t2_timeout", timeout_o, 0);
    settle("t2");

    // 3: bad check byte, then SYNC used as command
    do_reset();
    send(8'hAA, 0); send(8'h3C, 0); send(8'h00, 0);
    send(8'hAA, 1); send(8'hAA, 0); send(8'h55, 0);
    settle("t3");
    chk("t3_action_abs", action_o, 8'hAA);
    chk("t3_err_abs", err_count_o, 1);

    // 4: resync on failed check byte equal to SYNC
    do_reset();
    send(8'hAA, 0); send(8'h3C, 0); send(8'hAA, 0); send(8'h12, 0); send(8'hED, 0);
    settle("t4");
    chk("t4_action_abs", action_o, 8'h12);
    chk("t4_err_abs", err_count_o, 1);

    // 5: byte timeout after SYNC, remaining bytes ignored in idle
    do_reset();
    send(8'hAA, 0); send(8'h3C, T); send(8'hC3, 0);
    settle("t5");
    chk("t5_action_abs", action_o, 8'h00);
    chk("t5_err_abs", err_count_o, 1);

    // Gap of T-1 idle cycles is still inside the frame window
    send(8'hAA, 2); send(8'h3C, T - 1); send(8'hC3, T - 1);
    settle("tmo_edge");
    chk("tmo_edge_action_abs", action_o, 8'h3C);

    // 6: watchdog expiry, then no further pulses
    do_reset();
    send(8'hAA, 0); send(8'h5A, 0); send(8'hA5, 0);
    idle(W + 5);
    chk("t6_action_abs", action_o, 8'h00);
    chk("t6_timeout_abs", timeout_o, 1);
    idle(2 * W);
    settle("t6");

    // Accept on the same edge the watchdog would expire
    send(8'hAA, 0); send(8'h77, 0); send(8'h88, 0);
    send(8'hAA, W - 3); send(8'h3C, 0); send(8'hC3, 0);
    settle("coincide");
    chk("coincide_timeout_abs", timeout_o, 0);

    // Mid-frame reset drops the partial frame
    send(8'hAA, 0); send(8'h3C, 0);
    do_reset();
    send(8'hC3, 0);
    settle("midreset");

    // Error counter saturation
    for (int i = 0; i < 260; i++) begin
      send(8'hAA, 0); send(8'h01, 0); send(8'h00, 0);
    end
    settle("sat");
    chk("sat_err_abs", err_count_o, 8'hFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      c    = 8'($urandom);
      if (kind < 6) begin
        send(SYNC, rg()); send(c, rg()); send(~c, rg());
      end else if (kind < 8) begin
        send(8'($urandom), rg());
      end else begin
        send(SYNC, rg()); send(c, 0); send(c ^ 8'($urandom_range(1, 255)), 0);
      end
      if ($urandom_range(0, 24) == 0) idle(W + $urandom_range(0, 5));
    end
    settle("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
